// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable watermarks, occupancy count and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise data_out is registered.
module sync_fifo_prog #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned CW = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] data_in,
   input  logic             rd_en,
   input  logic [CW-1:0]    af_thresh,
   input  logic [CW-1:0]    ae_thresh,
   input  logic             err_clr,
   output logic [WIDTH-1:0] data_out,
   output logic             rd_valid,
   output logic             wr_ack,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [CW-1:0]    count,
   output logic             overflow,
   output logic             underflow,
   output logic             ovf_sticky,
   output logic             unf_sticky
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             ovf_q, unf_q;
   logic             rd_accept, wr_accept;

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign rd_accept = rd_en && !empty;
   // A read in the same cycle frees the slot, so a write at full is still taken.
   assign wr_accept = wr_en && (!full || rd_accept);

   assign wr_ack       = wr_accept;
   assign overflow     = wr_en && !wr_accept;
   assign underflow    = rd_en && empty;
   assign almost_full  = (count_q >= af_thresh);
   assign almost_empty = (count_q <= ae_thresh);
   assign count        = count_q;
   assign ovf_sticky   = ovf_q;
   assign unf_sticky   = unf_q;

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_accept) mem[wr_ptr_q] <= data_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         if (wr_accept) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_accept) rd_ptr_q <= rd_ptr_q + AW'(1);
         if (wr_accept && !rd_accept) begin
            count_q <= count_q + CW'(1);
         end else if (rd_accept && !wr_accept) begin
            count_q <= count_q - CW'(1);
         end
         if (overflow) begin
            ovf_q <= 1'b1;
         end else if (err_clr) begin
            ovf_q <= 1'b0;
         end
         if (underflow) begin
            unf_q <= 1'b1;
         end else if (err_clr) begin
            unf_q <= 1'b0;
         end
      end
   end

`ifdef FIFO_FWFT_EN
   assign data_out = empty ? '0 : mem[rd_ptr_q];
   assign rd_valid = !empty;
`else
   logic [WIDTH-1:0] data_q;
   logic             rd_valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q     <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_accept;
         if (rd_accept) data_q <= mem[rd_ptr_q];
      end
   end

   assign data_out = data_q;
   assign rd_valid = rd_valid_q;
`endif

endmodule

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

Parametrised single-clock FIFO and next-generation buffer for the verification environment. It generalises the basic FIFO in width and depth, and adds:
- run-time programmable almost-full/almost-empty thresholds;
- an occupancy count output;
- sticky overflow/underflow error flags with clear;
- read+write accepted together at full;
- an optional first-word-fall-through (FWFT) read mode.

It sits between a producer and a consumer that need back-pressure and watermarks.

## Interface
- WIDTH, 16, data word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥4
- CW (localparam), $clog2(DEPTH)+1, width of count and thresholds
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous, active-low
- wr_en  input  1  write request
- data_in  input  WIDTH  write data
- rd_en  input  1  read request
- af_thresh  input  CW  almost-full threshold
- ae_thresh  input  CW  almost-empty threshold
- err_clr  input  1  clears sticky error flags
- data_out  output  WIDTH  read data
- rd_valid  output  1  data_out carries newly read word
- wr_ack  output  1  write accepted this cycle (combinational)
- full, empty  output  1  count==DEPTH / count==0
- almost_full  output  1  count >= af_thresh
- almost_empty  output  1  count <= ae_thresh
- count  output  CW  current occupancy
- overflow, underflow  output  1  per-cycle rejected write / rejected read (combinational)
- ovf_sticky, unf_sticky  output  1  sticky error flags

## Operation
- Write accept: wr_en && (!full || rd_accept). A write is allowed at full when a read is accepted in the same cycle.
- Read accept: rd_en && !empty. A read is never accepted at empty, even with a simultaneous write.
- Accepted write: mem[wr_ptr] <= data_in; wr_ptr increments.
- Accepted read: rd_ptr increments.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither. Count never exceeds DEPTH and never goes below 0.
- overflow = wr_en && !wr_accept.
- underflow = rd_en && empty.
- Sticky flags:
  - ovf_sticky is set by overflow; unf_sticky is set by underflow.
  - Both flags are cleared by err_clr.
  - If set and clear occur in the same cycle, set wins.
- Thresholds are compared each cycle against the registered count, using unsigned comparison.
  - af_thresh=0 forces almost_full to 1.
  - ae_thresh ≥ DEPTH forces almost_empty to 1.
- Memory contents are not reset; reading is impossible until a write has occurred.

## Timing
- Reset (async assert, synchronous-to-clk deassert by the system) sets:
  - wr_ptr, rd_ptr, count = 0
  - data_out = 0, rd_valid = 0
  - ovf_sticky = 0, unf_sticky = 0
  - resulting outputs: empty = 1, full = 0, almost_empty = 1, almost_full = (af_thresh == 0)
- Reset mid-operation discards all stored data immediately. The first write after deassert lands at address 0.
- full, empty, almost_full, almost_empty and count reflect register state. They update on the edge after an accepted access.
- Standard mode:
  - data_out is registered and loaded on the clock edge that accepts a read.
  - rd_valid is 1 for the cycle following an accepted read.
  - data_out holds its value between reads.
  - Read latency is 1 cycle.
- Write-to-readable latency: a word written at edge N is readable (empty=0) in the cycle after edge N.
- Back-to-back reads and writes at full throughput are allowed, including continuous wr+rd at full or steady state.

## Configuration
- Macro: FIFO_FWFT_EN.
- Not defined: standard mode as described above.
- Defined: first-word-fall-through mode.
  - data_out = mem[rd_ptr] combinationally whenever !empty, and 0 when empty.
  - rd_valid = !empty, meaning the head word is valid.
  - rd_en acknowledges (pops) the head word; the next word appears in the cycle after the accepting edge.
  - A word written into an empty FIFO appears on data_out one cycle after its write edge.
  - All flags, counting and error rules are unchanged.

## Test plan
- Reset, then write 0x0001..0x0008 with DEPTH=8 -> full=1 after 8th edge, count=8, wr_ack=1 ×8; a 9th write gives overflow=1, ovf_sticky=1, count stays 8.
- From full, hold wr_en=rd_en=1 for 4 cycles with data 0xA0..0xA3 -> count stays 8, no overflow; reads return 0x0001..0x0004 (rd_valid one cycle after each); later drain returns 0x0005..0x0008 then 0xA0..0xA3, checking pointer wrap.
- Empty FIFO, wr_en=rd_en=1 with 0x5555 -> underflow=1, unf_sticky=1, write accepted, count=1; err_clr in the next cycle -> unf_sticky=0.
- af_thresh=6, ae_thresh=2, fill 0→8 then drain 8→0 -> almost_full=1 exactly at counts 6..8; almost_empty=1 exactly at counts 0..2.
- Write 5 words, assert rst_n=0 mid-cycle -> all outputs return to reset values immediately; after release, write 0x1234 then read -> data_out=0x1234.
- With FIFO_FWFT_EN: write 0xBEEF to empty -> data_out=0xBEEF and rd_valid=1 the next cycle with no rd_en; pulse rd_en -> empty=1, data_out=0.
